// File: rtl/uart_rx_full.sv
// uart_rx_full: 16x-oversampled UART receiver assembling DBIT/SIZ frames into one word, LSB byte first
module uart_rx_full #(
  parameter int DBIT    = 16,
  parameter int SIZ     = 8,
  parameter int SB_TICK = 16,
  parameter int DIV     = 163
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            rx,
  output logic [DBIT-1:0] o_Data,
  output logic            rx_done,
  output logic            frame_err
);
  localparam int KW = DBIT / SIZ;
  localparam int KB = KW > 1 ? $clog2(KW) : 1;
  localparam int NB = SIZ > 1 ? $clog2(SIZ) : 1;
  localparam int TB = $clog2(SB_TICK > 16 ? SB_TICK : 16);
  localparam int CB = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          r_state, w_next;
  logic [1:0]      r_sync;
  logic [CB-1:0]   r_div;
  logic [TB-1:0]   r_t;
  logic [NB-1:0]   r_n;
  logic [KB-1:0]   r_k;
  logic [SIZ-1:0]  r_sh;
  logic [DBIT-1:0] r_buf, w_word;
  logic            w_rx, w_tick, w_end, w_shift, w_good, w_bad, w_full;
  assign w_rx   = r_sync[1];
  assign w_tick = r_div == CB'(DIV - 1);
  // last oversample tick of the current phase: mid start bit, mid data bit, stop sample
  assign w_end  = w_tick && (r_state == START ? r_t == TB'(7) :
                             r_state == DATA  ? r_t == TB'(15) :
                             r_state == STOP && r_t == TB'(SB_TICK - 1));
  always_ff @(posedge i_clock)
    r_state <= i_reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_rx ? IDLE : START;
      START:   if (w_end) w_next = w_rx ? IDLE : DATA;
      DATA:    if (w_end && r_n == NB'(SIZ - 1)) w_next = STOP;
      STOP:    if (w_end) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    w_shift = r_state == DATA && w_end;
    w_good  = r_state == STOP && w_end && w_rx;
    w_bad   = r_state == STOP && w_end && !w_rx;
    w_full  = w_good && r_k == KB'(KW - 1);
    w_word  = r_buf;
    for (int i = 0; i < KW; i++)
      if (r_k == KB'(i)) w_word[i*SIZ +: SIZ] = r_sh;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync    <= 2'b11;
      r_div     <= '0;
      r_t       <= '0;
      r_n       <= '0;
      r_k       <= '0;
      r_sh      <= '0;
      r_buf     <= '0;
      o_Data    <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], rx};
      r_div     <= w_tick ? '0 : r_div + 1'b1;
      r_t       <= r_state == IDLE || w_end ? '0 : w_tick ? r_t + 1'b1 : r_t;
      r_n       <= r_state == START ? '0 : w_shift ? r_n + 1'b1 : r_n;
      if (w_shift) r_sh <= {w_rx, r_sh[SIZ-1:1]};
      r_k       <= w_bad || w_full ? '0 : w_good ? r_k + 1'b1 : r_k;
      if (w_good) r_buf <= w_word;
      if (w_full) o_Data <= w_word;
      rx_done   <= w_full;
      frame_err <= w_bad;
    end
  end
endmodule

// File: doc/uart_rx_full.md
Name: uart_rx_full

Overview:
- UART receiver: the receive-side counterpart of the team's 16-bit word transmitter (uart_full).
- Oversamples the serial line at 16x baud and deserialises SIZ-bit frames (1 start, SIZ data LSB-first, 1 stop, no parity).
- Assembles DBIT/SIZ consecutive frames into one DBIT-bit word, least significant byte first.
- Presents the completed word with a one-cycle done strobe to the consuming datapath.

Parameters:
- DBIT, 16: assembled word width; must be an integer multiple of SIZ.
- SIZ, 8: data bits per UART frame.
- SB_TICK, 16: oversample ticks spanning the stop bit (16 = 1 stop bit).
- DIV, 163: clocks per oversample tick. At 50 MHz this gives ~19200 baud; one bit = 16*DIV = 2608 clocks.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- rx  in  1  serial input; idle high; asynchronous to i_clock.
- o_Data  out  DBIT  last completed word; holds until the next word completes.
- rx_done  out  1  one-cycle pulse when o_Data is updated.
- frame_err  out  1  one-cycle pulse on a stop-bit error.

Behaviour:
- One clock, i_clock. Reset is synchronous and active-high on i_reset. While i_reset is high at a rising edge:
  - state = IDLE; all counters = 0; shift register = 0.
  - o_Data = 0, rx_done = 0, frame_err = 0.
  - Synchroniser flops = 1.
- Synchroniser: rx passes through 2 flops (rx_s) before any use. All sampling refers to rx_s.
- Tick generator: free-running counter 0..DIV-1, cleared by reset. s_tick is high for 1 clock when count == DIV-1, so the period is DIV clocks.
- FSM states:
  - IDLE: on rx_s == 0, go to START and clear the tick count t.
  - START: count s_tick. At t == 7 (mid start bit):
    - if rx_s == 0, go to DATA with t = 0, bit count n = 0;
    - else it is a glitch: return to IDLE, byte count unchanged.
  - DATA: count s_tick. At t == 15, shift rx_s into the MSB of the SIZ-bit shift register (LSB-first line order), set t = 0, n = n + 1. After n == SIZ-1 is sampled, go to STOP.
  - STOP: count s_tick. At t == SB_TICK-1, sample rx_s:
    - 1 (good): store the byte into word slot k (bits k*SIZ+SIZ-1 : k*SIZ); k = k + 1. If k was DBIT/SIZ-1, the word is complete: copy the assembly buffer to o_Data, pulse rx_done, k = 0. Go to IDLE.
    - 0 (error): pulse frame_err; discard the partial word (k = 0, buffer untouched); go to IDLE.
- Latency: o_Data and rx_done update on the clock edge immediately after the final stop-bit sample tick. rx_done is high for exactly 1 clock. o_Data is stable at all other times.
- Bytes in a word may be separated by any idle gap; there is no inter-byte timeout.
- Falling edge during STOP: an rx_s falling edge while in STOP is not acted on until STOP completes. A new start bit is only detected from IDLE.
- rx_done and frame_err are never high in the same cycle.
- Reset mid-frame: returns to IDLE with k = 0; the partially received word is lost; no strobes are generated.
- Line held low continuously: after a frame_err, a new START is entered immediately from IDLE and repeats until the line rises. No lock-up.

Test Plan:
1. Reset 2 cycles, then send frames 0x04 then 0x00 (2608 clocks/bit) -> one rx_done pulse after the second stop bit; o_Data = 16'h0004; frame_err never asserted.
2. Send 0xAB, 0xCD, then 0x34, 0x12 back-to-back with no idle gap -> two rx_done pulses; o_Data = 16'hCDAB after the first, 16'h1234 after the second.
3. Drive rx low for 3*DIV clocks (shorter than half a bit), then high -> no rx_done, no frame_err; a following valid 0x55, 0xAA pair yields o_Data = 16'hAA55.
4. First frame 0x11 with stop bit forced 0 -> single frame_err pulse, no rx_done. Then 0x22, 0x33 -> o_Data = 16'h3322 (the 0x11 byte is not used).
5. Send 0x77, then assert i_reset during bit 3 of the second frame, release, then send 0x9A, 0xBC -> o_Data = 0 after reset; final o_Data = 16'hBC9A with exactly one rx_done.
6. Assert i_reset for 1 cycle at an arbitrary time while idle -> all outputs 0 the following cycle; tick period remeasured = 163 clocks.
